// File: rtl/test_result_uart_tx_if.sv
// rtl/test_result_uart_tx_if.sv - start/verdict capture and UART status bundle for test_result_uart_tx
interface test_result_uart_tx_if;
  logic        start_i;
  logic        pass_i;
  logic [31:0] code_i;
  logic        uart_tx_o;
  logic        busy_o;
  logic        done_o;

  modport master (
    output start_i, pass_i, code_i,
    input  uart_tx_o, busy_o, done_o
  );

  modport slave (
    input  start_i, pass_i, code_i,
    output uart_tx_o, busy_o, done_o
  );
endinterface

// File: rtl/test_result_uart_tx.sv
// rtl/test_result_uart_tx.sv - sends "PASS "/"FAIL " + 8 hex digits + CR LF over an 8N1 UART line
module test_result_uart_tx #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic                 clk,
  input  logic                 rst_n,
  test_result_uart_tx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [3:0]  char_idx;
  logic        pass_q;
  logic [31:0] code_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;

  logic [2:0]  nib_sel;
  logic [3:0]  nib;
  logic [7:0]  hex_byte;
  logic [7:0]  char_byte;
  logic [2:0]  next_bit;

  // Characters 5..12 carry code nibbles 7..0, most significant first.
  always_comb begin
    nib_sel  = 3'(4'd12 - char_idx);
    nib      = code_q[{nib_sel, 2'b00} +: 4];
    hex_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    next_bit = bit_cnt + 3'd1;
  end

  always_comb begin
    char_byte = 8'h00;
    case (char_idx)
      4'd0:    char_byte = pass_q ? 8'h50 : 8'h46;
      4'd1:    char_byte = 8'h41;
      4'd2:    char_byte = pass_q ? 8'h53 : 8'h49;
      4'd3:    char_byte = pass_q ? 8'h53 : 8'h4C;
      4'd4:    char_byte = 8'h20;
      4'd13:   char_byte = 8'h0D;
      4'd14:   char_byte = 8'h0A;
      4'd15:   char_byte = 8'h00;
      default: char_byte = hex_byte;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
      char_idx <= 4'd0;
      pass_q   <= 1'b0;
      code_q   <= 32'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            pass_q   <= bus.pass_i;
            code_q   <= bus.code_i;
            busy_q   <= 1'b1;
            tx_q     <= 1'b0;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            char_idx <= 4'd0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            tx_q     <= char_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= 16'd0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
              tx_q    <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= next_bit;
              tx_q    <= char_byte[next_bit];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= 16'd0;
            if (char_idx == 4'd14) begin
              char_idx <= 4'd0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state    <= IDLE;
            end else begin
              char_idx <= char_idx + 4'd1;
              tx_q     <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.uart_tx_o = tx_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;

endmodule

// File: tb/tb_test_result_uart_tx.sv
// tb/tb_test_result_uart_tx.sv - directed bench for test_result_uart_tx at CLK_DIV 4 and 5
module tb_test_result_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   gcyc = 0;
  int   done_cnt = 0;

  test_result_uart_tx_if bus4();
  test_result_uart_tx_if bus5();

  test_result_uart_tx #(.CLK_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  test_result_uart_tx #(.CLK_DIV(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  always #5 clk = ~clk;

  always @(posedge clk) if (bus4.done_o === 1'b1) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
    gcyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_tx(input int sel);
    return (sel != 0) ? bus5.uart_tx_o : bus4.uart_tx_o;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? bus5.busy_o : bus4.busy_o;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel != 0) ? bus5.done_o : bus4.done_o;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) bus5.start_i = v;
    else bus4.start_i = v;
  endtask

  // Call with start already driven; the first tick is the accept edge N.
  // Returns in cycle N+150*div+1 (the done cycle), before the next edge.
  task automatic run_record(input int sel, input int div, input logic [119:0] exp_rec,
                            input bit disturb, input bit keep_start, input string tag,
                            output int start_cyc);
    logic [7:0] got;
    logic       bitv;
    int         cyc;
    int         width_err;
    int         frame_err;
    int         flag_err;
    got = 8'h00;
    width_err = 0;
    frame_err = 0;
    flag_err = 0;
    start_cyc = gcyc;
    tick();
    cyc = 1;
    if (!keep_start) set_start(sel, 1'b0);
    chk({tag, " latency_tx"}, 32'(get_tx(sel)), 32'd0);
    for (int c = 0; c < 15; c++) begin
      for (int b = 0; b < 10; b++) begin
        bitv = get_tx(sel);
        if (b == 0 && bitv !== 1'b0) frame_err++;
        if (b == 9 && bitv !== 1'b1) frame_err++;
        if (b >= 1 && b <= 8) got[b-1] = bitv;
        for (int k = 0; k < div; k++) begin
          if (get_tx(sel) !== bitv) width_err++;
          if (get_busy(sel) !== 1'b1 || get_done(sel) !== 1'b0) flag_err++;
          if (disturb) begin
            if (cyc == 10 || cyc == 300 || cyc == 599) begin
              set_start(sel, 1'b1);
              bus4.pass_i = ~bus4.pass_i;
              bus4.code_i = 32'hFFFF_FFFF;
            end else begin
              set_start(sel, 1'b0);
            end
          end
          tick();
          cyc++;
        end
      end
      chk($sformatf("%s char%0d", tag, c), 32'(got), 32'(exp_rec[119-8*c -: 8]));
    end
    chk({tag, " end_cycle"}, 32'(cyc), 32'(150 * div + 1));
    chk({tag, " done_hi"}, 32'(get_done(sel)), 32'd1);
    chk({tag, " busy_lo"}, 32'(get_busy(sel)), 32'd0);
    chk({tag, " tx_idle"}, 32'(get_tx(sel)), 32'd1);
    chk({tag, " bit_width"}, 32'(width_err), 32'd0);
    chk({tag, " framing"}, 32'(frame_err), 32'd0);
    chk({tag, " busy_done_in_record"}, 32'(flag_err), 32'd0);
  endtask

  localparam logic [119:0] REC_PASS1 = 120'h50_41_53_53_20_30_30_30_30_30_30_30_31_0D_0A;
  localparam logic [119:0] REC_DEAD  = 120'h46_41_49_4C_20_44_45_41_44_42_45_45_46_0D_0A;
  localparam logic [119:0] REC_1234  = 120'h50_41_53_53_20_31_32_33_34_35_36_37_38_0D_0A;
  localparam logic [119:0] REC_CAFE  = 120'h50_41_53_53_20_43_41_46_45_30_30_34_32_0D_0A;
  localparam logic [119:0] REC_BAD   = 120'h46_41_49_4C_20_30_42_41_44_43_30_44_45_0D_0A;

  initial begin
    int s0, s1, s2, s3, d0;
    bus4.start_i = 1'b1;
    bus4.pass_i  = 1'b1;
    bus4.code_i  = 32'h0;
    bus5.start_i = 1'b1;
    bus5.pass_i  = 1'b0;
    bus5.code_i  = 32'h0;

    // Reset held with start requested
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst tx", 32'(bus4.uart_tx_o), 32'd1);
      chk("rst busy", 32'(bus4.busy_o), 32'd0);
      chk("rst done", 32'(bus4.done_o), 32'd0);
      chk("rst tx5", 32'(bus5.uart_tx_o), 32'd1);
    end
    bus4.start_i = 1'b0;
    bus5.start_i = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst tx", 32'(bus4.uart_tx_o), 32'd1);
    chk("post_rst busy", 32'(bus4.busy_o), 32'd0);

    // PASS record, divider 4
    bus4.pass_i = 1'b1;
    bus4.code_i = 32'h0000_0001;
    bus4.start_i = 1'b1;
    d0 = done_cnt;
    run_record(0, 4, REC_PASS1, 1'b0, 1'b0, "pass4", s0);
    tick();
    chk("pass4 done_drop", 32'(bus4.done_o), 32'd0);
    chk("pass4 done_count", 32'(done_cnt - d0), 32'd1);

    // FAIL record, divider 5
    bus5.pass_i = 1'b0;
    bus5.code_i = 32'hDEAD_BEEF;
    bus5.start_i = 1'b1;
    run_record(1, 5, REC_DEAD, 1'b0, 1'b0, "fail5", s0);
    tick();
    chk("fail5 done_drop", 32'(bus5.done_o), 32'd0);

    // Inputs changed and start pulsed mid-record are ignored
    bus4.pass_i = 1'b1;
    bus4.code_i = 32'h1234_5678;
    bus4.start_i = 1'b1;
    d0 = done_cnt;
    run_record(0, 4, REC_1234, 1'b1, 1'b0, "ignore", s0);
    bus4.start_i = 1'b0;
    repeat (3) tick();
    chk("ignore done_count", 32'(done_cnt - d0), 32'd1);
    chk("ignore stays_idle", 32'(bus4.busy_o), 32'd0);

    // Back-to-back with start held high
    bus4.pass_i = 1'b1;
    bus4.code_i = 32'hCAFE_0042;
    bus4.start_i = 1'b1;
    d0 = done_cnt;
    run_record(0, 4, REC_CAFE, 1'b0, 1'b1, "b2b_0", s1);
    run_record(0, 4, REC_CAFE, 1'b0, 1'b1, "b2b_1", s2);
    run_record(0, 4, REC_CAFE, 1'b0, 1'b1, "b2b_2", s3);
    bus4.start_i = 1'b0;
    repeat (2) tick();
    chk("b2b period01", 32'(s2 - s1), 32'd601);
    chk("b2b period12", 32'(s3 - s2), 32'd601);
    chk("b2b done_count", 32'(done_cnt - d0), 32'd3);

    // Reset during data bit 3 of character 7 (a '0' digit, bit low)
    bus4.pass_i = 1'b1;
    bus4.code_i = 32'h0000_0000;
    bus4.start_i = 1'b1;
    tick();
    bus4.start_i = 1'b0;
    repeat (297) tick();
    chk("midrst pre_tx", 32'(bus4.uart_tx_o), 32'd0);
    chk("midrst pre_busy", 32'(bus4.busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst async_tx", 32'(bus4.uart_tx_o), 32'd1);
    chk("midrst async_busy", 32'(bus4.busy_o), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("midrst idle_tx", 32'(bus4.uart_tx_o), 32'd1);
    bus4.pass_i = 1'b0;
    bus4.code_i = 32'h0BAD_C0DE;
    bus4.start_i = 1'b1;
    run_record(0, 4, REC_BAD, 1'b0, 1'b0, "after_rst", s0);
    tick();
    chk("after_rst done_drop", 32'(bus4.done_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/test_result_uart_tx.md
# test_result_uart_tx

Serialises a test verdict to the host over a single 8N1 UART transmit line. On one start pulse it captures a pass/fail flag and a 32-bit value, then sends one fixed 15-character ASCII record: "PASS " or "FAIL ", eight uppercase hex digits, then CR LF. It sits in the FPGA top beside the tohost/PC completion monitor, which drives it when a test finishes. It gives the bench and the board the same result stream on a UART pin that the LEDs show visually.

## Interface
- CLK_DIV, 434, clk cycles per UART bit (434 = 50 MHz / 115200); legal range 2..65535.
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start_i  input  1  request to send one record; sampled every cycle.
- pass_i  input  1  verdict: 1 sends "PASS", 0 sends "FAIL"; captured with start.
- code_i  input  32  value printed as hex (e.g. x3 or cycle count); captured with start.
- uart_tx_o  output  1  serial line, idle high, registered.
- busy_o  output  1  record in progress, registered.
- done_o  output  1  one-cycle pulse when the last stop bit ends, registered.

## Operation
- Reset (async, immediate, including mid-frame): uart_tx_o=1, busy_o=0, done_o=0, FSM=IDLE, all counters 0, captured regs 0.
- Accept: start_i=1 while busy_o=0. At that edge, latch pass_i and code_i, set busy_o=1, and enter START. start_i while busy_o=1 is ignored and not queued.
- Changes on pass_i or code_i after acceptance have no effect on the current record.
- Record, character index 0..14, MSB-nibble first:
  - "PASS" = 0x50 0x41 0x53 0x53.
  - "FAIL" = 0x46 0x41 0x49 0x4C.
  - Then 0x20.
  - Then hex of code_i[31:28] down to [3:0]: nibble 0–9 -> 0x30+n; nibble 10–15 -> 0x41+(n−10).
  - Then 0x0D 0x0A.
- Frame per character: start bit 0, 8 data bits LSB first, 1 stop bit 1. No parity, no inter-character gap.
- FSM states:
  - IDLE -> START on accept.
  - START (tx=0) -> DATA after CLK_DIV cycles.
  - DATA (tx=data[bit]) advances bit 0..7, then -> STOP.
  - STOP (tx=1) -> START with char+1 if char<14. If char==14 -> IDLE, busy_o=0, done_o=1 for one cycle.
- Baud counter counts 0..CLK_DIV−1 and wraps, reloaded to 0 on every state/bit change. Bit counter is 3 bits; character counter is 4 bits; no other wrap.
- Character bytes are generated combinationally from the character index and the latched regs, and registered into the output path.

## Timing
- Accept at edge N: from N+1, uart_tx_o=0 and busy_o=1.
- Each bit lasts exactly CLK_DIV cycles. A character lasts 10·CLK_DIV cycles; a record lasts 150·CLK_DIV cycles.
- Last stop bit occupies cycles N+1+149·CLK_DIV .. N+150·CLK_DIV.
- After edge N+150·CLK_DIV: done_o=1, busy_o=0, uart_tx_o=1.
- done_o drops after one cycle.
- Back-to-back: start_i=1 in the done_o cycle is accepted (busy_o=0). The next start bit begins one cycle later, so the stop bit is stretched by exactly 1 cycle; no other gap.
- Start asserted in the same cycle as rst_n deassertion edge: accepted only if sampled at a clk edge with rst_n=1.
- Latency from accept to first line transition: 1 cycle.

## Test plan
- Reset: hold rst_n=0 with start_i=1 -> uart_tx_o=1, busy_o=0, done_o=0 throughout. Deassert with start_i=0 -> line stays idle high.
- PASS record, CLK_DIV=4, pass_i=1, code_i=0x00000001, start at edge N -> UART monitor decodes 50 41 53 53 20 30 30 30 30 30 30 30 31 0D 0A. done_o is high only in the cycle after edge N+600; busy_o is high over N+1..N+600.
- FAIL record, CLK_DIV=5, pass_i=0, code_i=0xDEADBEEF -> decodes 46 41 49 4C 20 44 45 41 44 42 45 45 46 0D 0A. Every bit is exactly 5 cycles wide.
- Capture/ignore: CLK_DIV=4. After accept, toggle pass_i, change code_i to 0xFFFFFFFF, and pulse start_i at cycles 10, 300, 599 -> record is unchanged and only one done_o pulse is produced.
- Back-to-back: start_i held high continuously, CLK_DIV=4 -> records repeat. Each record is 601 cycles apart, one done_o per record, and the gap between records is exactly 1 extra high cycle.
- Reset mid-record: assert rst_n=0 during DATA of character 7 -> uart_tx_o=1 and busy_o=0 asynchronously. After release plus a new start, a complete, correct record is sent from character 0.
